// File: rtl/player_input_if.sv
// Player input bundle: tick/enable strobes, raw buttons and the per-tick
// command outputs of player_input_controller.
// master = stimulus side (game logic / bench), slave = the controller.
interface player_input_if;
  logic       game_tick;
  logic       enable;
  logic       btn_left;
  logic       btn_right;
  logic       btn_jump;
  logic       btn_attack;
  logic       moving_left;
  logic       moving_right;
  logic       is_jumping;
  logic       attack_active;
  logic [1:0] attack_phase;
  logic       busy;

  modport master (
    output game_tick, enable, btn_left, btn_right, btn_jump, btn_attack,
    input  moving_left, moving_right, is_jumping, attack_active, attack_phase, busy
  );

  modport slave (
    input  game_tick, enable, btn_left, btn_right, btn_jump, btn_attack,
    output moving_left, moving_right, is_jumping, attack_active, attack_phase, busy
  );
endinterface

// File: rtl/player_input_controller.sv
// player_input_controller: synchronizes and debounces the four player
// buttons, captures jump/attack presses, and on each game_tick updates the
// movement/jump commands and steps the attack frame FSM
// (IDLE -> STARTUP -> ACTIVE -> RECOVERY -> IDLE).
// Optional macro ATTACK_BUFFER_EN: an attack press during RECOVERY chains
// straight into a new STARTUP instead of passing through IDLE.
module player_input_controller #(
  parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000,
  parameter logic [2:0]  STARTUP_TICKS   = 3'd2,
  parameter logic [2:0]  ACTIVE_TICKS    = 3'd3,
  parameter logic [2:0]  RECOVERY_TICKS  = 3'd4
) (
  input  logic            clk,
  input  logic            reset,
  player_input_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    STARTUP  = 2'd1,
    ACTIVE   = 2'd2,
    RECOVERY = 2'd3
  } state_t;

  // Button index: 0 left, 1 right, 2 jump, 3 attack.
  logic [3:0]       sync1, sync2, db, db_rise;
  logic [3:0][15:0] db_cnt;

  state_t     state, state_next;
  logic [2:0] phase_cnt, phase_cnt_next;
  logic       jump_pending, attack_pending;
  logic       jump_req, attack_req, next_idle;
  logic       moving_left_q, moving_right_q, is_jumping_q, attack_active_q, busy_q;
  logic [1:0] attack_phase_q;
`ifdef ATTACK_BUFFER_EN
  logic       attack_buffered, buf_req;
`endif

  // Two-flop synchronizer followed by a per-button saturating debouncer.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1  <= '0;
      sync2  <= '0;
      db     <= '0;
      db_cnt <= '0;
    end else begin
      sync1 <= {bus.btn_attack, bus.btn_jump, bus.btn_right, bus.btn_left};
      sync2 <= sync1;
      for (int i = 0; i < 4; i++) begin
        if (sync2[i] != db[i]) begin
          if (db_cnt[i] == DEBOUNCE_CYCLES - 16'd1) begin
            db[i]     <= ~db[i];
            db_cnt[i] <= '0;
          end else begin
            db_cnt[i] <= db_cnt[i] + 16'd1;
          end
        end else begin
          db_cnt[i] <= '0;
        end
      end
    end
  end

  // Debounced rising edge: flagged in the clk where the level is about to go high.
  always_comb begin
    for (int i = 0; i < 4; i++)
      db_rise[i] = ~db[i] & sync2[i] & (db_cnt[i] == DEBOUNCE_CYCLES - 16'd1);
  end

  // Next attack state and the request terms a tick would consume.
  // NOTE: every always_comb output gets a default first, so no latch is inferred.
  always_comb begin
    state_next     = state;
    phase_cnt_next = phase_cnt;
    jump_req       = jump_pending   | (db_rise[2] & (state == IDLE) & bus.enable);
    attack_req     = attack_pending | (db_rise[3] & (state == IDLE) & bus.enable);
`ifdef ATTACK_BUFFER_EN
    buf_req        = attack_buffered | (db_rise[3] & (state == RECOVERY) & bus.enable);
`endif
    case (state)
      IDLE: begin
        if (attack_req && bus.enable) begin
          state_next     = STARTUP;
          phase_cnt_next = STARTUP_TICKS - 3'd1;
        end
      end
      STARTUP: begin
        if (phase_cnt == 3'd0) begin
          state_next     = ACTIVE;
          phase_cnt_next = ACTIVE_TICKS - 3'd1;
        end else begin
          phase_cnt_next = phase_cnt - 3'd1;
        end
      end
      ACTIVE: begin
        if (phase_cnt == 3'd0) begin
          state_next     = RECOVERY;
          phase_cnt_next = RECOVERY_TICKS - 3'd1;
        end else begin
          phase_cnt_next = phase_cnt - 3'd1;
        end
      end
      RECOVERY: begin
        if (phase_cnt == 3'd0) begin
          state_next     = IDLE;
          phase_cnt_next = 3'd0;
`ifdef ATTACK_BUFFER_EN
          if (buf_req && bus.enable) begin
            state_next     = STARTUP;
            phase_cnt_next = STARTUP_TICKS - 3'd1;
          end
`endif
        end else begin
          phase_cnt_next = phase_cnt - 3'd1;
        end
      end
      default: state_next = IDLE;
    endcase
    next_idle = (state_next == IDLE);
  end

  // Attack FSM, press capture and registered command outputs, all advanced on game_tick.
  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= IDLE;
      phase_cnt       <= '0;
      jump_pending    <= 1'b0;
      attack_pending  <= 1'b0;
      moving_left_q   <= 1'b0;
      moving_right_q  <= 1'b0;
      is_jumping_q    <= 1'b0;
      attack_active_q <= 1'b0;
      attack_phase_q  <= 2'd0;
      busy_q          <= 1'b0;
`ifdef ATTACK_BUFFER_EN
      attack_buffered <= 1'b0;
`endif
    end else if (bus.game_tick) begin
      state           <= state_next;
      phase_cnt       <= phase_cnt_next;
      attack_phase_q  <= state_next;
      busy_q          <= (state_next != IDLE);
      attack_active_q <= (state_next == ACTIVE);
      moving_left_q   <= db[0] & ~db[1] & bus.enable & next_idle;
      moving_right_q  <= db[1] & ~db[0] & bus.enable & next_idle;
      is_jumping_q    <= jump_req & bus.enable & next_idle;
      jump_pending    <= 1'b0;
      attack_pending  <= 1'b0;
`ifdef ATTACK_BUFFER_EN
      attack_buffered <= buf_req & bus.enable & (state_next == RECOVERY);
`endif
    end else begin
      if (db_rise[2] && state == IDLE && bus.enable) jump_pending   <= 1'b1;
      if (db_rise[3] && state == IDLE && bus.enable) attack_pending <= 1'b1;
`ifdef ATTACK_BUFFER_EN
      if (db_rise[3] && state == RECOVERY && bus.enable) attack_buffered <= 1'b1;
`endif
    end
  end

  assign bus.moving_left   = moving_left_q;
  assign bus.moving_right  = moving_right_q;
  assign bus.is_jumping    = is_jumping_q;
  assign bus.attack_active = attack_active_q;
  assign bus.attack_phase  = attack_phase_q;
  assign bus.busy          = busy_q;

endmodule

// File: tb/tb_player_input_controller.sv
// Self-checking bench for player_input_controller (DEBOUNCE_CYCLES=4).
// Each tick pushes its expected command set onto a scoreboard queue; the
// entry is popped and compared once the tick has been registered.
module tb_player_input_controller;

  logic clk = 1'b0;
  logic reset;
  player_input_if bus ();

  player_input_controller #(.DEBOUNCE_CYCLES(16'd4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string      tag;
    logic       ml;
    logic       mr;
    logic       jmp;
    logic [1:0] ph;
  } exp_t;

  exp_t sb_q[$];

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic clocks(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Pop the oldest expectation and compare it against the current outputs.
  task automatic sb_compare();
    exp_t e;
    if (sb_q.size() == 0) begin
      check("sb_underflow", 32'd0, 32'd1);
    end else begin
      e = sb_q.pop_front();
      check({e.tag, ".ml"},     32'(bus.moving_left),   32'(e.ml));
      check({e.tag, ".mr"},     32'(bus.moving_right),  32'(e.mr));
      check({e.tag, ".jmp"},    32'(bus.is_jumping),    32'(e.jmp));
      check({e.tag, ".ph"},     32'(bus.attack_phase),  32'(e.ph));
      check({e.tag, ".active"}, 32'(bus.attack_active), 32'(e.ph == 2'd2));
      check({e.tag, ".busy"},   32'(bus.busy),          32'(e.ph != 2'd0));
    end
  endtask

  // Issue one game_tick with its expectation queued beforehand.
  task automatic tick_exp(input string tag, input logic ml, input logic mr,
                          input logic jmp, input logic [1:0] ph);
    exp_t e;
    e.tag = tag; e.ml = ml; e.mr = mr; e.jmp = jmp; e.ph = ph;
    sb_q.push_back(e);
    @(negedge clk) bus.game_tick = 1'b1;
    @(negedge clk) bus.game_tick = 1'b0;
    sb_compare();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".ml"},     32'(bus.moving_left),   32'd0);
    check({tag, ".mr"},     32'(bus.moving_right),  32'd0);
    check({tag, ".jmp"},    32'(bus.is_jumping),    32'd0);
    check({tag, ".active"}, 32'(bus.attack_active), 32'd0);
    check({tag, ".ph"},     32'(bus.attack_phase),  32'd0);
    check({tag, ".busy"},   32'(bus.busy),          32'd0);
  endtask

  initial begin
    logic [1:0] seq [10];
    seq = '{2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd3, 2'd3, 2'd3, 2'd3, 2'd0};

    reset = 1'b1;
    bus.game_tick = 1'b0; bus.enable = 1'b1;
    bus.btn_left = 1'b0; bus.btn_right = 1'b0; bus.btn_jump = 1'b0; bus.btn_attack = 1'b0;
    clocks(3);
    check_all_zero("reset");
    reset = 1'b0;
    clocks(2);

    // Glitch of 3 clk is shorter than the debounce window.
    bus.btn_left = 1'b1; clocks(3); bus.btn_left = 1'b0;
    clocks(8);
    tick_exp("glitch_t1", 0, 0, 0, 2'd0);
    tick_exp("glitch_t2", 0, 0, 0, 2'd0);

    // Left held, then both, then right alone.
    bus.btn_left = 1'b1; clocks(10);
    tick_exp("left", 1, 0, 0, 2'd0);
    clocks(3);
    check("left_hold_no_tick", 32'(bus.moving_left), 32'd1);
    bus.btn_right = 1'b1; clocks(10);
    tick_exp("both", 0, 0, 0, 2'd0);
    bus.btn_left = 1'b0; clocks(10);
    tick_exp("right", 0, 1, 0, 2'd0);
    bus.btn_right = 1'b0; clocks(10);
    tick_exp("none", 0, 0, 0, 2'd0);

    // Jump held across three ticks fires once.
    bus.btn_jump = 1'b1; clocks(10);
    tick_exp("jump_t1", 0, 0, 1, 2'd0);
    tick_exp("jump_t2", 0, 0, 0, 2'd0);
    tick_exp("jump_t3", 0, 0, 0, 2'd0);
    bus.btn_jump = 1'b0; clocks(10);

    // Full attack with left held; movement resumes at the return to IDLE.
    bus.btn_left = 1'b1; bus.btn_attack = 1'b1; clocks(10);
    for (int i = 0; i < 10; i++) begin
      tick_exp($sformatf("atk_%0d", i), (i == 9), 0, 0, seq[i]);
      if (i == 0) bus.btn_attack = 1'b0;
    end
    bus.btn_left = 1'b0; clocks(10);
    tick_exp("atk_done", 0, 0, 0, 2'd0);

    // Jump and attack before the same tick: attack wins; then reset in ACTIVE.
    bus.btn_jump = 1'b1; bus.btn_attack = 1'b1; clocks(10);
    tick_exp("jmp_atk_t1", 0, 0, 0, 2'd1);
    tick_exp("jmp_atk_t2", 0, 0, 0, 2'd1);
    tick_exp("jmp_atk_t3", 0, 0, 0, 2'd2);
    bus.btn_jump = 1'b0; bus.btn_attack = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    check_all_zero("reset_active");
    clocks(3);
    reset = 1'b0;
    clocks(10);
    tick_exp("post_reset", 0, 0, 0, 2'd0);

    // Attack re-pressed during the second RECOVERY tick.
    bus.btn_attack = 1'b1; clocks(10);
    tick_exp("buf_start", 0, 0, 0, 2'd1);
    bus.btn_attack = 1'b0; clocks(10);
    for (int i = 1; i < 7; i++) tick_exp($sformatf("buf_%0d", i), 0, 0, 0, seq[i]);
    bus.btn_attack = 1'b1; clocks(10);
    tick_exp("buf_rec3", 0, 0, 0, 2'd3);
    tick_exp("buf_rec4", 0, 0, 0, 2'd3);
`ifdef ATTACK_BUFFER_EN
    tick_exp("buf_chain", 0, 0, 0, 2'd1);
    bus.btn_attack = 1'b0;
    for (int i = 1; i < 10; i++) tick_exp($sformatf("buf2_%0d", i), 0, 0, 0, seq[i]);
`else
    tick_exp("nobuf_idle", 0, 0, 0, 2'd0);
    tick_exp("nobuf_stay", 0, 0, 0, 2'd0);
    bus.btn_attack = 1'b0;
`endif
    clocks(10);
    tick_exp("end_idle", 0, 0, 0, 2'd0);

    check("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
